// File: rtl/guia_pkg.sv
// Shared definitions for the gate-checker guides: FSM state encoding and
// reference truth tables reused by the NOR/AND/OR/XOR checkers.
package guia_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Bit i is the expected gate output for input vector i.
  localparam logic [3:0] NOR_TT = 4'b0001;

  function automatic int cntWidth(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Stimulus/response bundle between the truth-table checker (slave) and the
// bench/gate side (master) that starts runs and feeds back the gate output.
interface truth_table_checker_if #(
  parameter int N_IN = 2
);

  logic            start;
  logic [N_IN-1:0] vec;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] fail_vec;
  logic            fail_valid;

  modport master (
    output start, dut_out,
    input  vec, busy, done, pass, err_count, fail_vec, fail_valid
  );

  modport slave (
    input  start, dut_out,
    output vec, busy, done, pass, err_count, fail_vec, fail_valid
  );

endinterface

// File: rtl/settle_timer.sv
// Loadable up/down counter whose terminal-count flag tells the checker FSM
// when the gate has had enough cycles to settle.
module settle_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] loadVal_i,
  input  logic [WIDTH-1:0] termVal_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Load wins over counting so a restart never sees a stale count.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadVal_i;
    end else if (en_i) begin
      count_d = up_i ? count_q + 1'b1 : count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == termVal_i);

endmodule

// File: rtl/truth_table_checker.sv
// Walks every input vector through a combinational gate, waits SETTLE cycles,
// and checks each response against EXPECTED, keeping a mismatch tally.
module truth_table_checker
  import guia_pkg::*;
#(
  parameter int                    N_IN     = 2,
  parameter logic [(2**N_IN)-1:0]  EXPECTED = NOR_TT,
  parameter int                    SETTLE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_checker_if.slave  bus
);

  localparam int              CW       = cntWidth(SETTLE);
  localparam logic [CW-1:0]   TERM     = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN-1:0] failVec_q, failVec_d;
  logic [N_IN:0]   errCount_q, errCount_d;
  logic            failValid_q, failValid_d;
  logic            pass_q, pass_d;
  logic            cntLoad, cntEn, cntTc;
  logic            mismatch;

  settle_timer #(.WIDTH(CW)) u_settle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cntLoad),
    .en_i      (cntEn),
    .up_i      (1'b1),
    .loadVal_i ('0),
    .termVal_i (TERM),
    .tc_o      (cntTc)
  );

  assign mismatch = (bus.dut_out != EXPECTED[vec_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.start) state_d = S_SETTLE;
      S_SETTLE: if (cntTc) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (vec_q == LAST_VEC) ? S_DONE : S_SETTLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    bus.done = (state_q == S_DONE);
    cntLoad  = ((state_q == S_IDLE) && bus.start) || (state_q == S_SAMPLE);
    cntEn    = (state_q == S_SETTLE);
  end

  // Sampling happens only in SAMPLE, one cycle after vec last moved.
  always_comb begin
    vec_d       = vec_q;
    failVec_d   = failVec_q;
    errCount_d  = errCount_q;
    failValid_d = failValid_q;
    pass_d      = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          vec_d       = '0;
          errCount_d  = '0;
          failValid_d = 1'b0;
          pass_d      = 1'b0;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          errCount_d = errCount_q + 1'b1;
          if (!failValid_q) begin
            failVec_d   = vec_q;
            failValid_d = 1'b1;
          end
        end
        if (vec_q != LAST_VEC) begin
          vec_d = vec_q + 1'b1;
        end
      end
      S_DONE:   pass_d = (errCount_q == '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q       <= '0;
      failVec_q   <= '0;
      errCount_q  <= '0;
      failValid_q <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      vec_q       <= vec_d;
      failVec_q   <= failVec_d;
      errCount_q  <= errCount_d;
      failValid_q <= failValid_d;
      pass_q      <= pass_d;
    end
  end

  assign bus.vec        = vec_q;
  assign bus.err_count  = errCount_q;
  assign bus.fail_vec   = failVec_q;
  assign bus.fail_valid = failValid_q;
  assign bus.pass       = pass_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: swaps gate models under a default
// instance and runs a second instance with a longer settle time.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   modeA = 0;

  logic [1:0] oVec, oFailVec;
  logic [2:0] oErr;
  logic       oBusy, oDone, oPass, oFailValid;

  always #5 clk = ~clk;

  truth_table_checker_if #(.N_IN(2)) busA ();
  truth_table_checker_if #(.N_IN(2)) busB ();

  truth_table_checker #(.N_IN(2), .EXPECTED(4'b0001), .SETTLE(1)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  truth_table_checker #(.N_IN(2), .EXPECTED(4'b0001), .SETTLE(3)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  // Gate models: 0 NOR, 1 OR, 2 stuck-at-0, 3 stuck-at-1; vec[1] is input a.
  function automatic logic gateModel(input int m, input logic [1:0] v);
    case (m)
      0:       return ~(v[1] | v[0]);
      1:       return v[1] | v[0];
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign busA.dut_out = gateModel(modeA, busA.vec);
  assign busB.dut_out = gateModel(0, busB.vec);

  task automatic peek(input int which);
    if (which == 0) begin
      oVec = busA.vec; oBusy = busA.busy; oDone = busA.done; oPass = busA.pass;
      oErr = busA.err_count; oFailVec = busA.fail_vec; oFailValid = busA.fail_valid;
    end else begin
      oVec = busB.vec; oBusy = busB.busy; oDone = busB.done; oPass = busB.pass;
      oErr = busB.err_count; oFailVec = busB.fail_vec; oFailValid = busB.fail_valid;
    end
  endtask

  task automatic setStart(input int which, input logic v);
    if (which == 0) busA.start = v;
    else            busB.start = v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " vec"},        32'(oVec), 0);
    checkOutput({tag, " busy"},       32'(oBusy), 0);
    checkOutput({tag, " done"},       32'(oDone), 0);
    checkOutput({tag, " pass"},       32'(oPass), 0);
    checkOutput({tag, " err_count"},  32'(oErr), 0);
    checkOutput({tag, " fail_vec"},   32'(oFailVec), 0);
    checkOutput({tag, " fail_valid"}, 32'(oFailValid), 0);
  endtask

  // One full run observed mid-cycle; cycle 0 is the cycle start is high.
  task automatic applyStimulus(input int which, input int settle, input int mode,
                               input bit preStarted, input bit pulses, input bit chain,
                               input int expErr, input bit expFailValid, input int expFailVec,
                               input bit expPass, input string tag);
    int last;
    int doneAt;
    int doneCnt;
    last    = 4 * (settle + 1) + 2;
    doneAt  = -1;
    doneCnt = 0;
    if (which == 0) modeA = mode;
    if (!preStarted) begin
      @(negedge clk);
      setStart(which, 1'b1);
    end
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      peek(which);
      if (oDone) begin
        doneCnt++;
        doneAt = c;
      end
      if (c == 1) begin
        checkOutput({tag, " c1 vec"},        32'(oVec), 0);
        checkOutput({tag, " c1 busy"},       32'(oBusy), 1);
        checkOutput({tag, " c1 err_count"},  32'(oErr), 0);
        checkOutput({tag, " c1 fail_valid"}, 32'(oFailValid), 0);
      end else if ((c % (settle + 1) == 0) && (c <= 4 * (settle + 1))) begin
        checkOutput($sformatf("%s sample c%0d vec", tag, c), 32'(oVec), 32'(c / (settle + 1) - 1));
        checkOutput($sformatf("%s sample c%0d busy", tag, c), 32'(oBusy), 1);
      end else if (c == last - 1) begin
        checkOutput({tag, " done-cycle busy"}, 32'(oBusy), 0);
      end else if (c == last) begin
        checkOutput({tag, " done cycle"},  32'(doneAt), 32'(last - 1));
        checkOutput({tag, " done pulses"}, 32'(doneCnt), 1);
        checkOutput({tag, " pass"},        32'(oPass), 32'(expPass));
        checkOutput({tag, " err_count"},   32'(oErr), 32'(expErr));
        checkOutput({tag, " fail_valid"},  32'(oFailValid), 32'(expFailValid));
        checkOutput({tag, " vec hold"},    32'(oVec), 3);
        if (expFailValid) checkOutput({tag, " fail_vec"}, 32'(oFailVec), 32'(expFailVec));
      end
      setStart(which, (pulses && (c == 3 || c == last - 1)) || (chain && c == last));
    end
  endtask

  initial begin
    busA.start = 1'b0;
    busB.start = 1'b0;
    repeat (2) @(negedge clk);
    peek(0);
    checkAllZero("reset");
    rst_n = 1'b1;

    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "nor");
    applyStimulus(0, 1, 1, 0, 0, 0, 4, 1, 0, 0, "or");
    applyStimulus(0, 1, 2, 0, 0, 0, 1, 1, 0, 0, "stuck0");
    applyStimulus(0, 1, 3, 0, 1, 1, 3, 1, 1, 0, "stuck1+ignored");
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, "rerun");

    // Mid-run reset while vector 2 is settling (cycle 5).
    modeA = 3;
    @(negedge clk);
    setStart(0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      setStart(0, 1'b0);
    end
    peek(0);
    checkOutput("pre-reset vec",       32'(oVec), 2);
    checkOutput("pre-reset err_count", 32'(oErr), 1);
    checkOutput("pre-reset fail_vec",  32'(oFailVec), 1);
    rst_n = 1'b0;
    #1;
    peek(0);
    checkAllZero("midrun reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "post-reset");
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 1, "settle3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
